// File: rtl/count_seq_ctrl_if.sv
// count_seq_ctrl_if: control/status bundle between the sequencer and its controller.
interface count_seq_ctrl_if #(parameter int WIDTH = 2, parameter int LEN_W = 8);
  logic             start;
  logic             dir;
  logic [LEN_W-1:0] len;
  logic             pause;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             busy;
  logic             done;
  logic             wrap;
  modport master (output start, dir, len, pause, load, load_val, input q, qb, busy, done, wrap);
  modport slave  (input start, dir, len, pause, load, load_val, output q, qb, busy, done, wrap);
endinterface

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: runs a WIDTH-bit count register up/down for a programmed number of steps.
module count_seq_ctrl #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 8
) (
  input logic             clk,
  input logic             clear,
  count_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_q;
  logic [LEN_W-1:0] r_rem;
  logic             r_dir, r_wrap;
  logic             w_step, w_load, w_start;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = bus.start ? (bus.len != '0 ? RUN : DONE) : IDLE;
      RUN:     w_next = bus.pause ? HOLD : (r_rem == LEN_W'(1) ? DONE : RUN);
      HOLD:    w_next = bus.pause ? HOLD : RUN;
      default: w_next = IDLE;
    endcase
  end
  assign w_step  = (r_state == RUN) && !bus.pause;
  assign w_load  = bus.load && (r_state == IDLE || r_state == HOLD);
  assign w_start = bus.start && (r_state == IDLE);
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_q     <= w_load ? bus.load_val : w_step ? (r_dir ? r_q - WIDTH'(1) : r_q + WIDTH'(1)) : r_q;
      r_rem   <= w_start ? bus.len : w_step ? r_rem - LEN_W'(1) : r_rem;
      r_dir   <= w_start ? bus.dir : r_dir;
      // wrap looks at the pre-step value, so a load can never raise it
      r_wrap  <= w_step && (r_dir ? (r_q == '0) : (&r_q));
    end
  end
  assign bus.q    = r_q;
  assign bus.qb   = ~r_q;
  assign bus.busy = (r_state == RUN) || (r_state == HOLD);
  assign bus.done = (r_state == DONE);
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_count_seq_ctrl;
  localparam int W = 2;
  localparam int L = 8;
  localparam int MOD = 1 << W;
  logic clk = 1'b0;
  logic clear = 1'b1;
  int checks = 0;
  int errors = 0;
  count_seq_ctrl_if #(.WIDTH(W), .LEN_W(L)) intf ();
  count_seq_ctrl #(.WIDTH(W), .LEN_W(L)) dut (.clk(clk), .clear(clear), .bus(intf.slave));
  always #5 clk = ~clk;
  int m_q, m_left;
  bit m_run, m_hold, m_done, m_dir, m_wrap;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_q = 0; m_left = 0; m_run = 0; m_hold = 0; m_done = 0; m_dir = 0; m_wrap = 0;
    end else begin : mdl
      bit stp, wr;
      stp = m_run && !intf.pause;
      wr  = stp && (m_dir ? m_q == 0 : m_q == MOD - 1);
      if (m_done) m_done = 0;
      else if (m_run) begin
        if (intf.pause) begin m_run = 0; m_hold = 1; end
        else begin
          m_q = (m_q + (m_dir ? MOD - 1 : 1)) % MOD;
          m_left--;
          if (m_left == 0) begin m_run = 0; m_done = 1; end
        end
      end else if (m_hold) begin
        if (intf.load) m_q = int'(intf.load_val);
        if (!intf.pause) begin m_hold = 0; m_run = 1; end
      end else begin
        if (intf.load) m_q = int'(intf.load_val);
        if (intf.start) begin
          m_dir = intf.dir;
          m_left = int'(intf.len);
          if (m_left == 0) m_done = 1; else m_run = 1;
        end
      end
      m_wrap = wr;
    end
  end
  always @(negedge clk) begin
    if (!clear) begin
      chk("q", int'(intf.q), m_q);
      chk("qb", int'(intf.qb), (~m_q) & (MOD - 1));
      chk("busy", int'(intf.busy), int'(m_run || m_hold));
      chk("done", int'(intf.done), int'(m_done));
      chk("wrap", int'(intf.wrap), int'(m_wrap));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lit_q(input string n, input int e);
    chk(n, int'(intf.q), e);
    chk({n, "_model"}, m_q, e);
  endtask
  initial begin
    int up_seq[5];
    up_seq = '{1, 2, 3, 0, 1};
    intf.start = 0; intf.dir = 0; intf.len = '0; intf.pause = 0; intf.load = 0; intf.load_val = '0;
    repeat (2) @(posedge clk);
    #1 clear = 0;
    chk("rst_q", int'(intf.q), 0);
    chk("rst_qb", int'(intf.qb), 3);
    chk("rst_busy", int'(intf.busy), 0);
    // async clear mid-run
    intf.dir = 0; intf.len = 5; intf.start = 1;
    tick(); intf.start = 0;
    tick(); tick();
    lit_q("t1_q_before_clear", 2);
    #1 clear = 1;
    #1;
    chk("t1_async_q", int'(intf.q), 0);
    chk("t1_async_qb", int'(intf.qb), 3);
    chk("t1_async_busy", int'(intf.busy), 0);
    chk("t1_async_done", int'(intf.done), 0);
    #1 clear = 0;
    repeat (6) begin tick(); chk("t1_no_done", int'(intf.done), 0); end
    // up run with wrap
    intf.dir = 0; intf.len = 5; intf.start = 1;
    tick(); intf.start = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lit_q("t2_q", up_seq[i]);
      chk("t2_wrap", int'(intf.wrap), int'(i == 3));
      chk("t2_done", int'(intf.done), int'(i == 4));
    end
    tick();
    lit_q("t2_idle_q", 1);
    chk("t2_idle_busy", int'(intf.busy), 0);
    // down run after load
    intf.load = 1; intf.load_val = 2;
    tick(); intf.load = 0;
    lit_q("t3_load", 2);
    intf.dir = 1; intf.len = 3; intf.start = 1;
    tick(); intf.start = 0;
    tick(); lit_q("t3_q1", 1);
    tick(); lit_q("t3_q2", 0);
    tick(); lit_q("t3_q3", 3);
    chk("t3_wrap", int'(intf.wrap), 1);
    chk("t3_done", int'(intf.done), 1);
    tick();
    // pause with load in HOLD, start+load together in IDLE
    intf.load = 1; intf.load_val = 0; intf.start = 1; intf.dir = 0; intf.len = 4;
    tick(); intf.load = 0; intf.start = 0;
    lit_q("t4_start_load", 0);
    tick(); lit_q("t4_e1", 1);
    tick(); lit_q("t4_e2", 2);
    intf.pause = 1;
    tick(); lit_q("t4_hold", 2); chk("t4_busy_h1", int'(intf.busy), 1);
    intf.load = 1; intf.load_val = 0;
    tick(); lit_q("t4_hold_load", 0); chk("t4_busy_h2", int'(intf.busy), 1);
    intf.load = 0;
    tick(); lit_q("t4_hold3", 0);
    intf.pause = 0;
    tick(); lit_q("t4_resume", 0); chk("t4_busy_r", int'(intf.busy), 1);
    tick(); lit_q("t4_e3", 1);
    tick(); lit_q("t4_e4", 2); chk("t4_done", int'(intf.done), 1);
    tick();
    chk("t4_idle", int'(intf.busy), 0);
    // zero length
    intf.len = 0; intf.start = 1;
    tick(); intf.start = 0;
    lit_q("t5_q", 2);
    chk("t5_busy", int'(intf.busy), 0);
    chk("t5_done", int'(intf.done), 1);
    tick(); chk("t5_done_off", int'(intf.done), 0);
    // start/load ignored during RUN and DONE
    intf.dir = 0; intf.len = 3; intf.start = 1;
    tick();
    intf.load = 1; intf.load_val = 0;
    tick(); lit_q("t6_e1", 3);
    tick(); lit_q("t6_e2", 0);
    tick(); lit_q("t6_e3", 1); chk("t6_done", int'(intf.done), 1);
    tick(); lit_q("t6_after_done", 1); chk("t6_busy", int'(intf.busy), 0);
    intf.start = 0; intf.load = 0;
    tick(); chk("t6_no_restart", int'(intf.busy), 0);
    // randomized traffic, checked by the compare process every cycle
    for (int i = 0; i < 800; i++) begin
      intf.start    = ($urandom_range(0, 3) == 0);
      intf.dir      = $urandom_range(0, 1) != 0;
      intf.len      = ($urandom_range(0, 15) == 0) ? L'($urandom_range(0, 40)) : L'($urandom_range(0, 6));
      intf.pause    = ($urandom_range(0, 4) == 0);
      intf.load     = ($urandom_range(0, 4) == 0);
      intf.load_val = W'($urandom_range(0, MOD - 1));
      if ($urandom_range(0, 99) == 0) begin
        #1 clear = 1;
        #1 clear = 0;
      end
      tick();
    end
    intf.start = 0; intf.load = 0; intf.pause = 0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
